// File: rtl/heartbeat_pkg.sv
// heartbeat_pkg: FSM state encodings and default sizing shared by the heartbeat monitor.
package heartbeat_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } state_t;
  localparam int CW_DEF      = 16;
  localparam int TIMEOUT_DEF = 1024;
endpackage

// File: rtl/heartbeat_edge.sv
// heartbeat_edge: optional 2-flop synchronizer plus rising-edge detector producing ev_o.
module heartbeat_edge #(
  parameter bit SYNC = 0
) (
  input  logic clk,
  input  logic nreset,
  input  logic beat_i,
  output logic ev_o
);
  logic r_q;
  logic w_beat_s;
  logic w_armed;
  // ev is held off until the history flop holds a real sample, so a level already high at release is not an edge
  if (SYNC) begin : g_sync
    logic [1:0] r_sync;
    logic [2:0] r_arm;
    always_ff @(posedge clk or negedge nreset)
      if (!nreset) begin
        r_sync <= '0;
        r_arm  <= '0;
      end else begin
        r_sync <= {r_sync[0], beat_i};
        r_arm  <= {r_arm[1:0], 1'b1};
      end
    assign w_beat_s = r_sync[1];
    assign w_armed  = r_arm[2];
  end else begin : g_direct
    logic r_arm;
    always_ff @(posedge clk or negedge nreset)
      if (!nreset) r_arm <= 1'b0;
      else r_arm <= 1'b1;
    assign w_beat_s = beat_i;
    assign w_armed  = r_arm;
  end
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) r_q <= 1'b0;
    else r_q <= w_beat_s;
  assign ev_o = w_beat_s & ~r_q & w_armed;
endmodule

// File: rtl/heartbeat_monitor.sv
// heartbeat_monitor: measures heartbeat period, declares lock and raises a sticky loss alarm.
module heartbeat_monitor
  import heartbeat_pkg::*;
#(
  parameter int CW         = CW_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int LOCK_BEATS = 4,
  parameter bit SYNC       = 0
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          beat_i,
  input  logic          clear_i,
  output logic          locked_o,
  output logic          alarm_o,
  output logic [CW-1:0] period_o,
  output logic [CW-1:0] beat_count_o
);
  localparam int LW = $clog2(LOCK_BEATS + 1);
  localparam logic [CW-1:0] TO = CW'(TIMEOUT);
  localparam logic [LW-1:0] LB = LW'(LOCK_BEATS);
  state_t r_state, w_state_nx;
  logic [CW-1:0] r_gap, r_period, r_count;
  logic [LW-1:0] r_lock_cnt, w_lock_nx;
  logic r_alarm;
  logic w_ev, w_timeout, w_first, w_enter_lost;

  heartbeat_edge #(.SYNC(SYNC)) u_edge (
    .clk    (clk),
    .nreset (nreset),
    .beat_i (beat_i),
    .ev_o   (w_ev)
  );

  assign w_timeout    = (r_gap >= TO) & ~w_ev;
  // IDLE and LOST are exactly the states whose next ev is the first of a run
  assign w_first      = (r_state == IDLE) | (r_state == LOST);
  assign w_enter_lost = (w_state_nx == LOST) & (r_state != LOST);

  always_comb begin
    w_state_nx = r_state;
    w_lock_nx  = r_lock_cnt;
    if (w_ev) begin
      w_lock_nx  = w_first ? LW'(1) : (r_state == LOCKING ? r_lock_cnt + LW'(1) : r_lock_cnt);
      w_state_nx = (w_lock_nx >= LB) ? LOCKED : LOCKING;
    end else if (w_timeout) begin
      w_state_nx = LOST;
      w_lock_nx  = '0;
    end
  end

  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      r_state    <= IDLE;
      r_lock_cnt <= '0;
      r_gap      <= '0;
      r_period   <= '0;
      r_count    <= '0;
      r_alarm    <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_lock_cnt <= w_lock_nx;
      r_gap      <= w_ev ? CW'(1) : (&r_gap ? r_gap : r_gap + CW'(1));
      if (w_ev & ~w_first) r_period <= r_gap;
      if (w_ev) r_count <= r_count + CW'(1);
      r_alarm    <= w_enter_lost | (r_alarm & ~clear_i);
    end

  assign locked_o     = (r_state == LOCKED);
  assign alarm_o      = r_alarm;
  assign period_o     = r_period;
  assign beat_count_o = r_count;
endmodule

// File: tb/tb_heartbeat_monitor.sv
// tb_heartbeat_monitor: scoreboard bench for the default monitor and a narrow CW=4 instance.
module tb_heartbeat_monitor;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic nreset0, beat0, clear0, lk0, al0;
  logic [15:0] per0, cnt0;
  logic nreset1, beat1, clear1, lk1, al1;
  logic [3:0] per1, cnt1;

  heartbeat_monitor #(.CW(16), .TIMEOUT(1024), .LOCK_BEATS(4), .SYNC(0)) u0 (
    .clk(clk), .nreset(nreset0), .beat_i(beat0), .clear_i(clear0),
    .locked_o(lk0), .alarm_o(al0), .period_o(per0), .beat_count_o(cnt0));
  heartbeat_monitor #(.CW(4), .TIMEOUT(15), .LOCK_BEATS(4), .SYNC(0)) u1 (
    .clk(clk), .nreset(nreset1), .beat_i(beat1), .clear_i(clear1),
    .locked_o(lk1), .alarm_o(al1), .period_o(per1), .beat_count_o(cnt1));

  bit sel = 1'b0;
  logic [15:0] o_cnt, o_per;
  logic o_lk, o_al;
  assign o_cnt = sel ? {12'b0, cnt1} : cnt0;
  assign o_per = sel ? {12'b0, per1} : per0;
  assign o_lk  = sel ? lk1 : lk0;
  assign o_al  = sel ? al1 : al0;

  typedef struct { int cnt; int per; bit lk; } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  int m_cnt, m_per, m_run, m_last, mask;
  bit m_first;

  task automatic model_reset();
    m_cnt = 0; m_per = 0; m_run = 0; m_last = 0; m_first = 1'b1;
    sb.delete();
  endtask

  task automatic model_loss();
    m_first = 1'b1; m_run = 0;
  endtask

  // called at a negedge; the rising beat is consumed at the next posedge
  task automatic do_beat(input int hi, input int total);
    exp_t e;
    if (sel) beat1 = 1'b1; else beat0 = 1'b1;
    m_cnt = (m_cnt + 1) & mask;
    if (!m_first) m_per = (cyc + 1 - m_last) & mask;
    m_last = cyc + 1;
    m_run = m_first ? 1 : m_run + 1;
    m_first = 1'b0;
    e.cnt = m_cnt; e.per = m_per; e.lk = (m_run >= 4);
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    checks += 3;
    if (o_cnt !== 16'(e.cnt)) begin errors++; $display("FAIL beat_count got %0d exp %0d", o_cnt, e.cnt); end
    if (o_per !== 16'(e.per)) begin errors++; $display("FAIL period got %0d exp %0d", o_per, e.per); end
    if (o_lk !== e.lk) begin errors++; $display("FAIL locked got %0b exp %0b", o_lk, e.lk); end
    repeat (hi - 1) @(negedge clk);
    if (sel) beat1 = 1'b0; else beat0 = 1'b0;
    repeat (total - hi) @(negedge clk);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic test_reset();
    sel = 1'b0; mask = 16'hFFFF; model_reset();
    nreset0 = 1'b0; beat0 = 1'b0; clear0 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_lk, o_al, o_per, o_cnt} !== 34'd0) begin errors++; $display("FAIL reset_held got %h exp 0", {o_lk, o_al, o_per, o_cnt}); end
    nreset0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({o_lk, o_al, o_per, o_cnt} !== 34'd0) begin errors++; $display("FAIL reset_idle%0d got %h exp 0", i, {o_lk, o_al, o_per, o_cnt}); end
    end
  endtask

  task automatic test_lock();
    for (int i = 0; i < 4; i++) do_beat(128, 256);
  endtask

  task automatic test_loss();
    wait_cyc(m_last + 1023);
    checks++;
    if ({o_lk, o_al} !== 2'b10) begin errors++; $display("FAIL pre_loss lk/al got %b exp 10", {o_lk, o_al}); end
    @(negedge clk);
    checks += 2;
    if ({o_lk, o_al} !== 2'b01) begin errors++; $display("FAIL loss lk/al got %b exp 01", {o_lk, o_al}); end
    if (o_per !== 16'(m_per)) begin errors++; $display("FAIL loss_period got %0d exp %0d", o_per, m_per); end
    model_loss();
  endtask

  task automatic test_clear_resume();
    clear0 = 1'b1;
    @(negedge clk);
    clear0 = 1'b0;
    checks++;
    if ({o_lk, o_al} !== 2'b00) begin errors++; $display("FAIL clear lk/al got %b exp 00", {o_lk, o_al}); end
    for (int i = 0; i < 4; i++) do_beat(128, 256);
    checks++;
    if (o_al !== 1'b0) begin errors++; $display("FAIL resume_alarm got %b exp 0", o_al); end
  endtask

  task automatic test_set_wins();
    wait_cyc(m_last + 1023);
    clear0 = 1'b1;
    @(negedge clk);
    clear0 = 1'b0;
    checks++;
    if ({o_lk, o_al} !== 2'b01) begin errors++; $display("FAIL set_wins lk/al got %b exp 01", {o_lk, o_al}); end
    model_loss();
    repeat (3) @(negedge clk);
    clear0 = 1'b1;
    @(negedge clk);
    clear0 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (o_al !== 1'b0) begin errors++; $display("FAIL lost_clear got %b exp 0", o_al); end
  endtask

  task automatic test_ev_at_timeout();
    for (int i = 0; i < 3; i++) do_beat(128, 256);
    do_beat(128, 1024);
    do_beat(128, 256);
    checks++;
    if ({o_lk, o_al} !== 2'b10) begin errors++; $display("FAIL ev_at_timeout lk/al got %b exp 10", {o_lk, o_al}); end
  endtask

  task automatic test_wrap();
    sel = 1'b1; mask = 15; model_reset();
    beat1 = 1'b0; clear1 = 1'b0;
    nreset1 = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 17; i++) do_beat(4, 8);
  endtask

  task automatic test_async_reset();
    nreset1 = 1'b0;
    @(negedge clk);
    nreset1 = 1'b1; model_reset();
    repeat (2) @(negedge clk);
    do_beat(4, 8);
    do_beat(4, 8);
    #2 nreset1 = 1'b0;
    #1;
    checks++;
    if ({o_lk, o_al, o_per, o_cnt} !== 34'd0) begin errors++; $display("FAIL async_reset got %h exp 0", {o_lk, o_al, o_per, o_cnt}); end
    @(negedge clk);
    nreset1 = 1'b1; model_reset();
  endtask

  task automatic test_held_high();
    exp_t e;
    repeat (2) @(negedge clk);
    beat1 = 1'b1;
    e.cnt = 1; e.per = 0; e.lk = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (o_cnt !== 16'(e.cnt)) begin errors++; $display("FAIL held_first got %0d exp %0d", o_cnt, e.cnt); end
    repeat (30) @(negedge clk);
    checks += 2;
    if (o_cnt !== 16'd1) begin errors++; $display("FAIL held_one_ev got %0d exp 1", o_cnt); end
    if ({o_lk, o_al} !== 2'b01) begin errors++; $display("FAIL held_lost lk/al got %b exp 01", {o_lk, o_al}); end
    beat1 = 1'b0;
  endtask

  initial begin
    nreset1 = 1'b0; beat1 = 1'b0; clear1 = 1'b0;
    test_reset();
    test_lock();
    test_loss();
    test_clear_resume();
    test_set_wins();
    test_ev_at_timeout();
    test_wrap();
    test_async_reset();
    test_held_high();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
